seq_divider: RTL and testbench

Sequential 8-bit restoring divider for the lab datapath: the inverse operation of the shift-add multiplier. Captures a dividend and divisor on a Start press, iterates one quotient bit per clock, applies sign correction, and holds Quotient/Remainder until the next press. Sits beside the multiplier under a lab top level, fed by debounced switches and buttons, with results routed to the hex driver.

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 156 +++++++++++++++
 tb/tb_seq_divider.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: run button and operands in, quotient,
// remainder and status flags out.
interface seq_divider_if;
  logic       Start;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       Div_Zero;
  logic       Overflow;

  modport master (
    output Start, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, Div_Zero, Overflow
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, Div_Zero, Overflow
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: 8-bit sequential restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands with sign correction and Overflow.
module seq_divider (
  input  logic         Clk,
  input  logic         Reset,
  seq_divider_if.slave div_if
);
  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

  state_t     state_q, state_d;
  logic       start_q;
  logic [7:0] dvd_q, dvd_d;
  logic [7:0] dvs_q, dvs_d;
  logic [7:0] q_q, q_d;
  logic [7:0] d_q, d_d;
  logic [7:0] r_q, r_d;
  logic [2:0] count_q, count_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] rem_q, rem_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       dz_q, dz_d;
  logic       ovf_q, ovf_d;

  logic       start_rise;
  logic [8:0] s;
  logic [7:0] dvd_mag, dvs_mag;
  logic       neg_quot, neg_rem, ovf_case;

  assign start_rise = div_if.Start & ~start_q;
  assign s          = {r_q, q_q[7]};

`ifdef DIVIDER_SIGNED_EN
  // |-128| wraps to 8'h80, which is exactly the unsigned magnitude 128.
  assign dvd_mag  = dvd_q[7] ? -dvd_q : dvd_q;
  assign dvs_mag  = dvs_q[7] ? -dvs_q : dvs_q;
  assign neg_quot = dvd_q[7] ^ dvs_q[7];
  assign neg_rem  = dvd_q[7];
  assign ovf_case = (dvd_q == 8'h80) && (dvs_q == 8'hFF);
`else
  assign dvd_mag  = dvd_q;
  assign dvs_mag  = dvs_q;
  assign neg_quot = 1'b0;
  assign neg_rem  = 1'b0;
  assign ovf_case = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          dvd_d   = div_if.Dividend;
          dvs_d   = div_if.Divisor;
          state_d = LOAD;
        end
      end
      LOAD: begin
        dz_d  = 1'b0;
        ovf_d = 1'b0;
        if (dvs_q == 8'h00) begin
          dz_d    = 1'b1;
          quot_d  = 8'hFF;
          rem_d   = dvd_q;
          state_d = DONE;
        end else begin
          q_d     = dvd_mag;
          d_d     = dvs_mag;
          r_d     = 8'h00;
          count_d = 3'd0;
          state_d = ITER;
        end
      end
      ITER: begin
        // Partial remainder stays below the divisor, so 8 bits hold it after the subtract.
        if (s >= {1'b0, d_q}) begin
          r_d = s[7:0] - d_q;
          q_d = {q_q[6:0], 1'b1};
        end else begin
          r_d = s[7:0];
          q_d = {q_q[6:0], 1'b0};
        end
        if (count_q == 3'd7) state_d = FIX;
        else                 count_d = count_q + 3'd1;
      end
      FIX: begin
        quot_d = neg_quot ? -q_q : q_q;
        rem_d  = neg_rem  ? -r_q : r_q;
        if (ovf_case) begin
          ovf_d  = 1'b1;
          quot_d = 8'h80;
          rem_d  = 8'h00;
        end
        state_d = DONE;
      end
      DONE: begin
        // Leave only once Done has been shown for at least one cycle.
        if (!div_if.Start && done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_q == LOAD) || (state_q == ITER);
    done_d = (state_d == DONE) && (state_q != LOAD);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      dvd_q   <= 8'h00;
      dvs_q   <= 8'h00;
      q_q     <= 8'h00;
      d_q     <= 8'h00;
      r_q     <= 8'h00;
      count_q <= 3'd0;
      quot_q  <= 8'h00;
      rem_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= div_if.Start;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign div_if.Quotient  = quot_q;
  assign div_if.Remainder = rem_q;
  assign div_if.Busy      = busy_q;
  assign div_if.Done      = done_q;
  assign div_if.Div_Zero  = dz_q;
  assign div_if.Overflow  = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed and random divisions compared
// against an arithmetic reference, plus latency, hold and reset behaviour.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_divider_if bus ();

  seq_divider dut (
    .Clk    (clk),
    .Reset  (rst),
    .div_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition of the division.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    sa = 0;
    sb = 0;
    if (b == 8'h00) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end
`ifdef DIVIDER_SIGNED_EN
    else if (a == 8'h80 && b == 8'hFF) begin
      q  = 8'h80;
      r  = 8'h00;
      ov = 1'b1;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
    end
`else
    else begin
      sa = int'(a);
      sb = int'(b);
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
    end
`endif
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [7:0] eq, er;
    logic       edz, eov;
    int         lat, busy_n, bad;
    string      tag;
    model(a, b, eq, er, edz, eov);
    tag = $sformatf("%02h/%02h", a, b);
    @(negedge clk);
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Start    = 1'b1;
    @(posedge clk); #1;
    bus.Dividend = 8'($urandom);
    bus.Divisor  = 8'($urandom);
    lat    = 0;
    busy_n = (bus.Busy === 1'b1) ? 1 : 0;
    while (bus.Done !== 1'b1 && lat < 30) begin
      if (lat == 3) bus.Start = 1'b0;
      if (lat == 5) bus.Start = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (bus.Busy === 1'b1) busy_n++;
    end
    $display("op %s -> q=%02h r=%02h dz=%b ov=%b lat=%0d (exp q=%02h r=%02h)",
             tag, bus.Quotient, bus.Remainder, bus.Div_Zero, bus.Overflow, lat, eq, er);
    chk({tag, " latency"},   16'(lat),    edz ? 16'd2 : 16'd10);
    chk({tag, " busy_cyc"},  16'(busy_n), edz ? 16'd1 : 16'd9);
    chk({tag, " quotient"},  16'(bus.Quotient),  16'(eq));
    chk({tag, " remainder"}, 16'(bus.Remainder), 16'(er));
    chk({tag, " div_zero"},  16'(bus.Div_Zero),  16'(edz));
    chk({tag, " overflow"},  16'(bus.Overflow),  16'(eov));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Quotient !== eq) bad++;
    end
    if (hold > 0) chk({tag, " hold"}, 16'(bad), 16'd0);
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " done_drop"}, 16'(bus.Done),     16'd0);
    chk({tag, " q_held"},    16'(bus.Quotient), 16'(eq));
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst          = 1'b1;
    bus.Start    = 1'b0;
    bus.Dividend = 8'h00;
    bus.Divisor  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quot", 16'(bus.Quotient), 16'h0);
    chk("rst_rem",  16'(bus.Remainder), 16'h0);
    chk("rst_flags", 16'({bus.Busy, bus.Done, bus.Div_Zero, bus.Overflow}), 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef DIVIDER_SIGNED_EN
    run_op(8'h64, 8'h07, 2);
    run_op(8'h9C, 8'h07, 0);
    run_op(8'h64, 8'hF9, 0);
    run_op(8'h80, 8'hFF, 1);
    run_op(8'h80, 8'h01, 0);
    run_op(8'h7F, 8'h80, 0);
`else
    run_op(8'hC8, 8'h07, 50);
    run_op(8'hFF, 8'h01, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h80, 8'hFF, 0);
`endif
    run_op(8'h05, 8'h00, 3);

    // Reset in the middle of an iteration, with Start held high across release.
    @(negedge clk);
    bus.Dividend = 8'h64;
    bus.Divisor  = 8'h07;
    bus.Start    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_quot", 16'(bus.Quotient), 16'h0);
    chk("midrst_rem",  16'(bus.Remainder), 16'h0);
    chk("midrst_flags", 16'({bus.Busy, bus.Done, bus.Div_Zero, bus.Overflow}), 16'h0);
    rst = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("held_start_idle", 16'({bus.Busy, bus.Done}), 16'h0);
    chk("held_start_quot", 16'(bus.Quotient), 16'h0);
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
